// File: rtl/aim65_kbd_pkg.sv
// Shared types and constants for the AIM65 PS/2-to-key-matrix emulator.
//   key_pos_t : keymap lookup result {valid, row, col, special}
//   spc_e     : special-action codes (SPC_NONE, SPC_VCLEAR)
//   hold_st_e : tap-stretch FSM states
//   SC_*      : PS/2 set-2 scancodes referenced by name
package aim65_kbd_pkg;

  localparam int unsigned ROW_W = 3;
  localparam int unsigned COL_W = 3;

  typedef enum logic [1:0] {
    SPC_NONE   = 2'd0,
    SPC_VCLEAR = 2'd1
  } spc_e;

  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    spc_e             special;
  } key_pos_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLDING  = 2'd1,
    ST_PEND_BRK = 2'd2
  } hold_st_e;

  localparam logic [7:0] SC_F4     = 8'h0C;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_RETURN = 8'h5A;

  // Build a plain matrix position (PA row, PB column).
  function automatic key_pos_t key_at(input int unsigned r, input int unsigned c);
    key_pos_t k;
    k.valid   = 1'b1;
    k.row     = ROW_W'(r);
    k.col     = COL_W'(c);
    k.special = SPC_NONE;
    return k;
  endfunction

endpackage

// File: rtl/aim65_keymap.sv
// Combinational PS/2 {ext,scancode} -> AIM65 matrix position lookup.
// Ports:
//   ext_i    : extended (E0) prefix flag
//   code_i   : set-2 scancode
//   pos_o_c  : {valid,row,col,special}; valid=0 for unmapped codes
module aim65_keymap
  import aim65_kbd_pkg::*;
(
  input  logic       ext_i,
  input  logic [7:0] code_i,
  output key_pos_t   pos_o_c
);

  always_comb begin
    pos_o_c = '0;
    if (!ext_i) begin
      case (code_i)
        // PA0
        SC_SPACE:  pos_o_c = key_at(0, 0);
        8'h1A:     pos_o_c = key_at(0, 1);  // Z
        8'h22:     pos_o_c = key_at(0, 2);  // X
        8'h21:     pos_o_c = key_at(0, 3);  // C
        8'h2A:     pos_o_c = key_at(0, 4);  // V
        8'h32:     pos_o_c = key_at(0, 5);  // B
        8'h31:     pos_o_c = key_at(0, 6);  // N
        8'h3A:     pos_o_c = key_at(0, 7);  // M
        // PA1
        8'h76:     pos_o_c = key_at(1, 0);  // ESC
        8'h41:     pos_o_c = key_at(1, 1);  // ,
        8'h49:     pos_o_c = key_at(1, 2);  // .
        8'h4A:     pos_o_c = key_at(1, 3);  // /
        8'h4C:     pos_o_c = key_at(1, 4);  // ;
        8'h4B:     pos_o_c = key_at(1, 5);  // L
        8'h1C:     pos_o_c = key_at(1, 6);  // A
        8'h42:     pos_o_c = key_at(1, 7);  // K
        // PA2
        8'h66:     pos_o_c = key_at(2, 0);  // DEL (backspace)
        8'h3B:     pos_o_c = key_at(2, 1);  // J
        8'h33:     pos_o_c = key_at(2, 2);  // H
        8'h34:     pos_o_c = key_at(2, 3);  // G
        8'h2B:     pos_o_c = key_at(2, 4);  // F
        8'h23:     pos_o_c = key_at(2, 5);  // D
        8'h4E:     pos_o_c = key_at(2, 6);  // -
        8'h4D:     pos_o_c = key_at(2, 7);  // P
        // PA3
        SC_RETURN: pos_o_c = key_at(3, 0);
        8'h44:     pos_o_c = key_at(3, 1);  // O
        8'h43:     pos_o_c = key_at(3, 2);  // I
        8'h3C:     pos_o_c = key_at(3, 3);  // U
        8'h35:     pos_o_c = key_at(3, 4);  // Y
        8'h2C:     pos_o_c = key_at(3, 5);  // T
        8'h2D:     pos_o_c = key_at(3, 6);  // R
        8'h15:     pos_o_c = key_at(3, 7);  // Q
        // PA4
        SC_CTRL:   pos_o_c = key_at(4, 0);
        8'h24:     pos_o_c = key_at(4, 1);  // E
        8'h1D:     pos_o_c = key_at(4, 2);  // W
        8'h45:     pos_o_c = key_at(4, 3);  // 0
        8'h46:     pos_o_c = key_at(4, 4);  // 9
        8'h3E:     pos_o_c = key_at(4, 5);  // 8
        8'h3D:     pos_o_c = key_at(4, 6);  // 7
        8'h36:     pos_o_c = key_at(4, 7);  // 6
        // PA5
        SC_RSHIFT: pos_o_c = key_at(5, 0);
        8'h2E:     pos_o_c = key_at(5, 1);  // 5
        8'h25:     pos_o_c = key_at(5, 2);  // 4
        8'h26:     pos_o_c = key_at(5, 3);  // 3
        8'h1E:     pos_o_c = key_at(5, 4);  // 2
        8'h16:     pos_o_c = key_at(5, 5);  // 1
        8'h05:     pos_o_c = key_at(5, 6);  // F1
        8'h06:     pos_o_c = key_at(5, 7);  // F2
        // PA6
        SC_LSHIFT: pos_o_c = key_at(6, 0);
        8'h04:     pos_o_c = key_at(6, 1);  // F3
        8'h52:     pos_o_c = key_at(6, 2);  // '
        8'h55:     pos_o_c = key_at(6, 3);  // =
        8'h54:     pos_o_c = key_at(6, 4);  // [
        8'h5B:     pos_o_c = key_at(6, 5);  // ]
        8'h1B:     pos_o_c = key_at(6, 6);  // S
        8'h0D:     pos_o_c = key_at(6, 7);  // TAB
        // PA7
        8'h5D:     pos_o_c = key_at(7, 4);  // backslash
        8'h03:     pos_o_c = key_at(7, 5);  // F5
        8'h0B:     pos_o_c = key_at(7, 6);  // F6
        8'h83:     pos_o_c = key_at(7, 7);  // F7
        // F4 is a host-side action, never a matrix cell
        SC_F4: begin
          pos_o_c.valid   = 1'b1;
          pos_o_c.special = SPC_VCLEAR;
        end
        default: ;
      endcase
    end else begin
      case (code_i)
        8'h75:     pos_o_c = key_at(7, 0);  // up
        8'h72:     pos_o_c = key_at(7, 1);  // down
        8'h6B:     pos_o_c = key_at(7, 2);  // left
        8'h74:     pos_o_c = key_at(7, 3);  // right
        SC_RETURN: pos_o_c = key_at(3, 0);  // keypad enter
        SC_CTRL:   pos_o_c = key_at(4, 0);  // right ctrl
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/aim65_matrix_kbd.sv
// PS/2-to-key-matrix emulator for the AIM65 RIOT 6532 keyboard port.
// Tracks make/break per cell, stretches short taps to MIN_HOLD cycles and
// answers PA row scans with a registered PB column word.
// Optional: define KBD_STUCK_RELEASE_EN to force-release the matrix after
// TIMEOUT cycles with no PS/2 strobe edge.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   ps2_key[10:0]: [10] toggle strobe, [9] make, [8] extended, [7:0] scancode
//   row_sel_n    : active-low row drive (RIOT PA)
//   col_n        : active-low column sense (RIOT PB), registered
//   video_clear  : display clear request (boot window and F4)
//   key_event    : 1-cycle pulse per accepted matrix make
//   any_down     : high while any matrix cell is down
module aim65_matrix_kbd
  import aim65_kbd_pkg::*;
#(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned MIN_HOLD = 20000,
  parameter int unsigned BOOT_CLR = 8,
  parameter int unsigned TIMEOUT  = 2**24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [10:0]     ps2_key,
  input  logic [ROWS-1:0] row_sel_n,
  output logic [COLS-1:0] col_n,
  output logic            video_clear,
  output logic            key_event,
  output logic            any_down
);

  localparam int unsigned HOLD_W = (MIN_HOLD < 1) ? 1 : $clog2(MIN_HOLD + 1);
  localparam int unsigned BOOT_W = (BOOT_CLR < 1) ? 1 : $clog2(BOOT_CLR + 1);

  logic [ROWS-1:0][COLS-1:0] matrix_q, matrix_d;
  hold_st_e                  state_q, state_d;
  logic [ROW_W-1:0]          last_row_q, last_row_d;
  logic [COL_W-1:0]          last_col_q, last_col_d;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic [BOOT_W-1:0]         boot_q, boot_d;
  logic                      stb_q, first_q;
  logic                      vclr_q, vclr_d;
  logic                      kev_q, kev_d;
  logic [COLS-1:0]           col_q, col_d;
  logic                      any_q;

  key_pos_t pos;
  logic     ev;
  logic     hit_last;
  logic     pend;

  aim65_keymap u_keymap (
    .ext_i   (ps2_key[8]),
    .code_i  (ps2_key[7:0]),
    .pos_o_c (pos)
  );

  // Strobe edge; the first cycle out of reset only samples the strobe level.
  assign ev = ~first_q & (ps2_key[10] ^ stb_q);

`ifdef KBD_STUCK_RELEASE_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Next-state: hold expiry, then the PS/2 event, then the stuck-key timeout.
  always_comb begin
    matrix_d   = matrix_q;
    state_d    = state_q;
    last_row_d = last_row_q;
    last_col_d = last_col_q;
    hold_d     = (hold_q == HOLD_W'(MIN_HOLD)) ? hold_q : hold_q + HOLD_W'(1);
    boot_d     = (boot_q == BOOT_W'(BOOT_CLR)) ? boot_q : boot_q + BOOT_W'(1);
    kev_d      = 1'b0;
    vclr_d     = 1'b0;
    hit_last   = (pos.row == last_row_q) && (pos.col == last_col_q);
    pend       = (state_q == ST_PEND_BRK);
`ifdef KBD_STUCK_RELEASE_EN
    idle_d     = ev ? '0 : idle_q + IDLE_W'(1);
`endif

    // Deferred release lands in the cycle the counter reaches MIN_HOLD.
    if (pend && (hold_d == HOLD_W'(MIN_HOLD))) begin
      matrix_d[last_row_q][last_col_q] = 1'b1;
      state_d = ST_IDLE;
    end

    if (ev && pos.valid) begin
      if (pos.special == SPC_VCLEAR) begin
        vclr_d = ps2_key[9];
      end else if (ps2_key[9]) begin
        // A cell still down from a pending break counts as a fresh press.
        if (matrix_q[pos.row][pos.col] || (pend && hit_last)) begin
          if (pend) begin
            matrix_d[last_row_q][last_col_q] = 1'b1;
          end
          matrix_d[pos.row][pos.col] = 1'b0;
          last_row_d = pos.row;
          last_col_d = pos.col;
          hold_d     = '0;
          kev_d      = 1'b1;
          state_d    = ST_HOLDING;
        end
      end else begin
        if ((state_q == ST_HOLDING) && hit_last && (hold_d < HOLD_W'(MIN_HOLD))) begin
          state_d = ST_PEND_BRK;
        end else if (!(pend && hit_last)) begin
          matrix_d[pos.row][pos.col] = 1'b1;
          if ((state_q == ST_HOLDING) && hit_last) begin
            state_d = ST_IDLE;
          end
        end
      end
    end

`ifdef KBD_STUCK_RELEASE_EN
    if (!ev && (idle_q == IDLE_W'(TIMEOUT - 1))) begin
      matrix_d = '1;
      state_d  = ST_IDLE;
      idle_d   = '0;
    end
`endif

    vclr_d = vclr_d | (boot_d < BOOT_W'(BOOT_CLR));
  end

  // Row scan: AND of every selected row, all-ones when none is driven.
  always_comb begin
    col_d = '1;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!row_sel_n[r]) begin
        col_d = col_d & matrix_q[r];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      matrix_q   <= '1;
      state_q    <= ST_IDLE;
      last_row_q <= '0;
      last_col_q <= '0;
      hold_q     <= '0;
      boot_q     <= '0;
      stb_q      <= 1'b0;
      first_q    <= 1'b1;
      vclr_q     <= 1'b1;
      kev_q      <= 1'b0;
      col_q      <= '1;
      any_q      <= 1'b0;
    end else begin
      matrix_q   <= matrix_d;
      state_q    <= state_d;
      last_row_q <= last_row_d;
      last_col_q <= last_col_d;
      hold_q     <= hold_d;
      boot_q     <= boot_d;
      stb_q      <= ps2_key[10];
      first_q    <= 1'b0;
      vclr_q     <= vclr_d;
      kev_q      <= kev_d;
      col_q      <= col_d;
      any_q      <= ~&matrix_q;
    end
  end

`ifdef KBD_STUCK_RELEASE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  assign col_n       = col_q;
  assign video_clear = vclr_q;
  assign key_event   = kev_q;
  assign any_down    = any_q;

endmodule
